// File: rtl/dcache_controller.sv
// dcache_controller
//   Direct-mapped, write-back, write-allocate data cache. It sits between the
//   memory-access stage and main data memory. Lines are 128 bits (4 words).
//   A miss fetches the whole block. If the victim line is dirty, it is written
//   back first. A single-cycle flush request writes back every dirty line and
//   then invalidates the whole cache.
//
// Ports
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   read, write          CPU load/store request (held until busywait is low)
//   address              CPU byte address: [3:2] word, [3+IB:4] index, [31:4+IB] tag
//   byte_en, writedata   store lanes and data
//   readdata, busywait   load data (same cycle on a hit) and CPU stall
//   flush, flush_done    flush request (ignored unless idle) / completion pulse
//   mem_read, mem_write  registered block requests, held stable until completion
//   mem_address          block address (byte address >> 4)
//   mem_writedata        victim block, word 0 in [31:0]
//   mem_readdata         fetched block, word 0 in [31:0]
//   mem_busywait         memory busy; low at an edge completes the request
module dcache_controller #(
   parameter int INDEX_BITS  = 3,
   parameter int MEM_REQ_MIN = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         read,
   input  logic         write,
   input  logic [31:0]  address,
   input  logic [3:0]   byte_en,
   input  logic [31:0]  writedata,
   output logic [31:0]  readdata,
   output logic         busywait,
   input  logic         flush,
   output logic         flush_done,
   output logic         mem_read,
   output logic         mem_write,
   output logic [27:0]  mem_address,
   output logic [127:0] mem_writedata,
   input  logic [127:0] mem_readdata,
   input  logic         mem_busywait
);

   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = 28 - INDEX_BITS;
   localparam logic [INDEX_BITS:0] SCAN_END   = (INDEX_BITS+1)'(LINES);
   localparam logic [7:0]          REQ_MIN_M1 = 8'(MEM_REQ_MIN - 1);

   typedef enum logic [2:0] {
      IDLE, WRITE_BACK, MEM_READ, FILL, FLUSH_SCAN, FLUSH_WB, FLUSH_DONE
   } state_t;

   state_t state, state_nxt;

   logic [127:0]      data_arr [LINES];
   logic [TAG_W-1:0]  tag_arr  [LINES];
   logic [LINES-1:0]  valid, dirty;
   logic [127:0]      fill_buf;
   logic [INDEX_BITS:0] scan_idx;
   logic [7:0]        req_cnt;

   logic [1:0]            word_sel;
   logic [INDEX_BITS-1:0] idx, scan_line;
   logic [TAG_W-1:0]      tag;
   logic                  hit, req_done, scan_last;
   logic [31:0]           cur_word, merged_word;
   logic                  unused_addr;

   logic do_write_hit, do_fill, do_inval, scan_adv, scan_start;
   logic issue_wb, issue_rd, issue_fwb, latch_fill, req_end;

   assign word_sel    = address[3:2];
   assign idx         = address[3+INDEX_BITS:4];
   assign tag         = address[31:4+INDEX_BITS];
   assign unused_addr = ^address[1:0];
   assign scan_line   = scan_idx[INDEX_BITS-1:0];
   assign scan_last   = (scan_idx + 1'b1) == SCAN_END;

   assign hit      = valid[idx] && (tag_arr[idx] == tag);
   assign cur_word = data_arr[idx][{word_sel, 5'b0} +: 32];
   // A request may only complete once it has been held MEM_REQ_MIN cycles.
   assign req_done = !mem_busywait && (req_cnt >= REQ_MIN_M1);

   always_comb begin
      merged_word = cur_word;
      for (int b = 0; b < 4; b++)
         if (byte_en[b]) merged_word[8*b +: 8] = writedata[8*b +: 8];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      busywait     = 1'b1;
      readdata     = '0;
      flush_done   = 1'b0;
      do_write_hit = 1'b0;
      do_fill      = 1'b0;
      do_inval     = 1'b0;
      scan_adv     = 1'b0;
      scan_start   = 1'b0;
      issue_wb     = 1'b0;
      issue_rd     = 1'b0;
      issue_fwb    = 1'b0;
      latch_fill   = 1'b0;
      req_end      = 1'b0;
      case (state)
         IDLE: begin
            busywait = 1'b0;
            if (flush) begin
               // flush wins; a coincident access stays stalled and replays
               busywait   = 1'b1;
               scan_start = 1'b1;
               state_nxt  = FLUSH_SCAN;
            end else if ((read || write) && !hit) begin
               busywait = 1'b1;
               if (valid[idx] && dirty[idx]) begin
                  issue_wb  = 1'b1;
                  state_nxt = WRITE_BACK;
               end else begin
                  issue_rd  = 1'b1;
                  state_nxt = MEM_READ;
               end
            end else if (read) begin
               readdata = cur_word;
            end else if (write) begin
               do_write_hit = 1'b1;
            end
         end
         WRITE_BACK: if (req_done) begin
            issue_rd  = 1'b1;
            state_nxt = MEM_READ;
         end
         MEM_READ: if (req_done) begin
            latch_fill = 1'b1;
            req_end    = 1'b1;
            state_nxt  = FILL;
         end
         FILL: begin
            do_fill   = 1'b1;
            state_nxt = IDLE;
         end
         FLUSH_SCAN: begin
            if (valid[scan_line] && dirty[scan_line]) begin
               issue_fwb = 1'b1;
               state_nxt = FLUSH_WB;
            end else begin
               do_inval  = 1'b1;
               scan_adv  = 1'b1;
               state_nxt = scan_last ? FLUSH_DONE : FLUSH_SCAN;
            end
         end
         FLUSH_WB: if (req_done) begin
            req_end   = 1'b1;
            do_inval  = 1'b1;
            scan_adv  = 1'b1;
            state_nxt = scan_last ? FLUSH_DONE : FLUSH_SCAN;
         end
         FLUSH_DONE: begin
            flush_done = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // control state, status bits and registered memory request
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid         <= '0;
         dirty         <= '0;
         scan_idx      <= '0;
         req_cnt       <= '0;
         fill_buf      <= '0;
         mem_read      <= 1'b0;
         mem_write     <= 1'b0;
         mem_address   <= '0;
         mem_writedata <= '0;
      end else begin
         // counts cycles spent in the current state; restarts on every change
         if (state_nxt != state)  req_cnt <= '0;
         else if (req_cnt != '1)  req_cnt <= req_cnt + 8'd1;

         if (scan_start)    scan_idx <= '0;
         else if (scan_adv) scan_idx <= scan_idx + 1'b1;

         if (latch_fill) fill_buf <= mem_readdata;

         if (do_fill) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
         end
         if (do_write_hit) dirty[idx] <= 1'b1;
         if (do_inval) begin
            valid[scan_line] <= 1'b0;
            dirty[scan_line] <= 1'b0;
         end

         if (issue_wb) begin
            mem_write     <= 1'b1;
            mem_read      <= 1'b0;
            mem_address   <= {tag_arr[idx], idx};
            mem_writedata <= data_arr[idx];
         end else if (issue_fwb) begin
            mem_write     <= 1'b1;
            mem_read      <= 1'b0;
            mem_address   <= {tag_arr[scan_line], scan_line};
            mem_writedata <= data_arr[scan_line];
         end else if (issue_rd) begin
            mem_write     <= 1'b0;
            mem_read      <= 1'b1;
            mem_address   <= address[31:4];
            mem_writedata <= '0;
         end else if (req_end) begin
            mem_write     <= 1'b0;
            mem_read      <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
         end
      end
   end

   // line storage carries no reset; valid bits guard its contents
   always_ff @(posedge clk) begin
      if (do_fill) begin
         data_arr[idx] <= fill_buf;
         tag_arr[idx]  <= tag;
      end else if (do_write_hit) begin
         data_arr[idx][{word_sel, 5'b0} +: 32] <= merged_word;
      end
   end

endmodule

// File: tb/tb_dcache_controller.sv
module tb_dcache_controller;

   logic         clk = 1'b0, reset = 1'b0;
   logic         read = 1'b0, write = 1'b0, flush = 1'b0;
   logic [31:0]  address = '0, writedata = '0;
   logic [3:0]   byte_en = '0;
   logic [31:0]  readdata;
   logic         busywait, flush_done, mem_read, mem_write, mem_busywait;
   logic [27:0]  mem_address;
   logic [127:0] mem_writedata;
   logic [127:0] mem_readdata = '0;

   int total = 0, bad = 0;
   int lat = 1, mcnt = 0, fd_cnt = 0;

   // main memory and the CPU-visible (architectural) word view
   logic [127:0] mem  [logic [27:0]];
   logic [31:0]  arch [logic [29:0]];
   logic [27:0]  wq_a [$];
   logic [127:0] wq_d [$];
   logic [27:0]  rq   [$];

   // cache bookkeeping: which block each line holds and whether it is modified
   bit          mv [8];
   bit          md [8];
   logic [24:0] mt [8];

   dcache_controller dut (
      .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
      .byte_en(byte_en), .writedata(writedata), .readdata(readdata),
      .busywait(busywait), .flush(flush), .flush_done(flush_done),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
      .mem_busywait(mem_busywait)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input logic [29:0] wa);
      if (wa[29:2] == 28'd4) return 32'h11111111 * (32'(wa[1:0]) + 32'd1);
      return (32'(wa) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   function automatic logic [127:0] mem_rd(input logic [27:0] b);
      logic [127:0] r;
      if (mem.exists(b)) return mem[b];
      for (int w = 0; w < 4; w++) r[32*w +: 32] = init_word({b, 2'(w)});
      return r;
   endfunction

   function automatic logic [31:0] arch_rd(input logic [29:0] wa);
      if (arch.exists(wa)) return arch[wa];
      return init_word(wa);
   endfunction

   function automatic logic [127:0] arch_blk(input logic [27:0] b);
      logic [127:0] r;
      for (int w = 0; w < 4; w++) r[32*w +: 32] = arch_rd({b, 2'(w)});
      return r;
   endfunction

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // memory: a request completes after being held lat cycles
   assign mem_busywait = !((mem_read || mem_write) && (mcnt == lat - 1));

   always @(posedge clk) begin
      if (mem_read || mem_write) begin
         if (!mem_busywait) begin
            if (mem_write) begin
               mem[mem_address] = mem_writedata;
               wq_a.push_back(mem_address);
               wq_d.push_back(mem_writedata);
            end else begin
               rq.push_back(mem_address);
            end
            mcnt <= 0;
         end else begin
            mcnt <= mcnt + 1;
         end
      end else begin
         mcnt <= 0;
      end
   end

   always @(negedge clk) mem_readdata = mem_rd(mem_address);

   // per-cycle compare: any unstalled load must return the architectural word
   always @(negedge clk) begin
      #2;
      if (reset) begin
         if (read && !busywait)
            check("read_data", readdata, arch_rd(address[31:2]));
         check("mem_rw_exclusive", mem_read & mem_write, 0);
         if (flush_done) fd_cnt++;
      end
   end

   task automatic clear_logs();
      wq_a.delete(); wq_d.delete(); rq.delete();
   endtask

   task automatic access(input bit rd, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input int L,
                         output int stalls, output logic [31:0] rdv);
      logic [2:0]   ix;
      logic [24:0]  tg;
      logic [27:0]  blk, va;
      logic [127:0] vd;
      logic [31:0]  w;
      bit           hit, vict;
      int           exp;
      ix   = a[6:4];
      tg   = a[31:7];
      blk  = a[31:4];
      hit  = mv[ix] && (mt[ix] == tg);
      vict = !hit && mv[ix] && md[ix];
      va   = {mt[ix], ix};
      vd   = arch_blk(va);
      exp  = hit ? 0 : (vict ? 2*L + 2 : L + 2);
      clear_logs();
      @(negedge clk);
      lat = L; read = rd; write = !rd; address = a; byte_en = be; writedata = wd;
      #1;
      stalls = 0;
      while (busywait && stalls < 100) begin
         stalls++;
         @(negedge clk);
         #1;
      end
      rdv = readdata;
      if (!rd) begin
         w = arch_rd(a[31:2]);
         for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
         arch[a[31:2]] = w;
      end
      @(negedge clk);
      read = 1'b0; write = 1'b0;
      check("stall_cycles", stalls, exp);
      check("wb_count", wq_a.size(), vict ? 1 : 0);
      if (vict && wq_a.size() > 0) begin
         check("wb_addr", wq_a[0], va);
         check("wb_data", wq_d[0], vd);
      end
      check("rd_count", rq.size(), hit ? 0 : 1);
      if (!hit && rq.size() > 0) check("rd_addr", rq[0], blk);
      if (!hit) begin
         mv[ix] = 1'b1; mt[ix] = tg; md[ix] = 1'b0;
      end
      if (!rd) md[ix] = 1'b1;
   endtask

   task automatic do_flush(input bit with_rd, input logic [31:0] a, input int L);
      logic [27:0]  ea [$];
      logic [127:0] ed [$];
      int nd, c, fd_at, fd0, exp_fd, exp_busy;
      nd = 0;
      for (int i = 0; i < 8; i++) if (mv[i] && md[i]) begin
         ea.push_back({mt[i], 3'(i)});
         ed.push_back(arch_blk({mt[i], 3'(i)}));
         nd++;
      end
      exp_fd   = 9 + L*nd;
      exp_busy = 10 + L*nd + (with_rd ? L + 2 : 0);
      clear_logs();
      fd0 = fd_cnt;
      @(negedge clk);
      lat = L; flush = 1'b1; read = with_rd; write = 1'b0; address = a;
      #1;
      c = 0; fd_at = -1;
      while (busywait && c < 300) begin
         if (flush_done && fd_at < 0) fd_at = c;
         c++;
         @(negedge clk);
         flush = 1'b0;
         #1;
      end
      @(negedge clk);
      read = 1'b0; flush = 1'b0;
      check("flush_busy_cycles", c, exp_busy);
      check("flush_done_cycle", fd_at, exp_fd);
      check("flush_done_pulses", fd_cnt - fd0, 1);
      check("flush_wb_count", wq_a.size(), nd);
      for (int i = 0; i < nd && i < wq_a.size(); i++) begin
         check("flush_wb_addr", wq_a[i], ea[i]);
         check("flush_wb_data", wq_d[i], ed[i]);
      end
      check("flush_rd_count", rq.size(), with_rd ? 1 : 0);
      for (int i = 0; i < 8; i++) begin mv[i] = 1'b0; md[i] = 1'b0; end
      if (with_rd) begin
         mv[a[6:4]] = 1'b1; mt[a[6:4]] = a[31:7];
      end
   endtask

   function automatic logic [31:0] rand_addr();
      return (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 4) |
             (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
   endfunction

   int           s;
   logic [31:0]  r;
   logic [127:0] blkv;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      #1;
      check("rst_readdata", readdata, 0);
      check("rst_busywait", busywait, 0);
      check("rst_flush_done", flush_done, 0);
      check("rst_mem_read", mem_read, 0);
      check("rst_mem_write", mem_write, 0);
      check("rst_mem_address", mem_address, 0);
      check("rst_mem_writedata", mem_writedata, 0);
      reset = 1'b1;

      // cold miss, then hits within the fetched block
      access(1'b1, 32'h40, 4'h0, 32'h0, 5, s, r);
      check("cold_stall_lit", s, 7);
      check("cold_data_lit", r, 32'h11111111);
      access(1'b1, 32'h48, 4'h0, 32'h0, 5, s, r);
      check("hit_stall_lit", s, 0);
      check("hit_data_lit", r, 32'h33333333);
      access(1'b0, 32'h44, 4'b0011, 32'hAABBCCDD, 5, s, r);
      check("write_hit_stall_lit", s, 0);
      access(1'b1, 32'h44, 4'h0, 32'h0, 5, s, r);
      check("merged_data_lit", r, 32'h2222CCDD);

      // conflict miss on a dirty line
      access(1'b1, 32'hC0, 4'h0, 32'h0, 5, s, r);
      check("dirty_miss_stall_lit", s, 12);
      check("victim_word1_lit", (wq_d.size() > 0) ? wq_d[0][63:32] : 32'hx, 32'h2222CCDD);
      check("victim_addr_lit", (wq_a.size() > 0) ? wq_a[0] : 28'hx, 28'h4);
      check("refill_addr_lit", (rq.size() > 0) ? rq[0] : 28'hx, 28'hC);

      // flush with exactly one dirty line
      access(1'b0, 32'hC0, 4'hF, 32'h12345678, 5, s, r);
      do_flush(1'b0, 32'h0, 4);
      check("flush_one_wb_lit", wq_a.size(), 1);
      access(1'b1, 32'hC0, 4'h0, 32'h0, 3, s, r);
      check("post_flush_miss_lit", s, 5);
      check("post_flush_data_lit", r, 32'h12345678);

      // flush arriving together with a load
      access(1'b0, 32'h1A4, 4'b1100, 32'hCAFEF00D, 2, s, r);
      do_flush(1'b1, 32'h48, 2);

      // randomized mix
      for (int i = 0; i < 300; i++) begin
         int k;
         k = $urandom_range(0, 99);
         if (k < 3)
            do_flush(1'b0, 32'h0, $urandom_range(1, 6));
         else if (k < 5)
            do_flush(1'b1, rand_addr(), $urandom_range(1, 6));
         else
            access($urandom_range(0, 1) == 1, rand_addr(), 4'($urandom_range(0, 15)),
                   $urandom, $urandom_range(1, 6), s, r);
      end

      // after a full flush main memory must hold every stored word
      do_flush(1'b0, 32'h0, 3);
      foreach (arch[k]) begin
         blkv = mem_rd(k[29:2]);
         check("mem_vs_arch", blkv[{k[1:0], 5'b0} +: 32], arch[k]);
      end

      // reset in the middle of a block read
      access(1'b1, 32'h200, 4'h0, 32'h0, 2, s, r);
      @(negedge clk);
      lat = 6; read = 1'b1; address = 32'h300;
      repeat (3) @(negedge clk);
      #1;
      check("pre_reset_mem_read", mem_read, 1);
      reset = 1'b0; read = 1'b0;
      #1;
      check("mid_reset_mem_read", mem_read, 0);
      check("mid_reset_busywait", busywait, 0);
      check("mid_reset_flush_done", flush_done, 0);
      check("mid_reset_mem_write", mem_write, 0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin mv[i] = 1'b0; md[i] = 1'b0; end
      access(1'b1, 32'h200, 4'h0, 32'h0, 3, s, r);
      check("after_reset_miss_lit", s, 5);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
